// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Write-back queue feeding the register-file write port. Results from the
//   execute/memory result mux are buffered in a small FIFO and retired at most
//   one per cycle as (wb_rd_o, wb_data_o, wb_regwrite_o). Results aimed at r0
//   are accepted but dropped. The register file itself is never touched here.
//
//   Optional build macro: WBQ_BYPASS_EN
//     defined   : combinational forwarding lookup on q_rs_i / q_rt_i that sees
//                 queued entries (youngest first), then the entry currently on
//                 the write port.
//     undefined : lookup ports ignored, forwarding outputs tied to zero.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-high reset
//   push_valid_i    producer offers a result
//   push_ready_o    queue not full (registered occupancy only)
//   push_rd_i       destination register of offered result
//   push_data_i     offered result value
//   wb_stall_i      hold retirement this cycle
//   wb_rd_o         register-file rd
//   wb_data_o       register-file write data
//   wb_regwrite_o   register-file RegWrite, one cycle per retired entry
//   q_count_o       occupancy 0..DEPTH
//   q_rs_i, q_rt_i  forwarding lookup addresses
//   fwd_rs_hit_o, fwd_rt_hit_o  lookup hit flags
//   fwd_rs_o, fwd_rt_o          forwarded values
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [4:0]       push_rd_i,
    input  logic [31:0]      push_data_i,
    input  logic             wb_stall_i,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_regwrite_o,
    output logic [PTR_W:0]   q_count_o,
    input  logic [4:0]       q_rs_i,
    input  logic [4:0]       q_rt_i,
    output logic             fwd_rs_hit_o,
    output logic             fwd_rt_hit_o,
    output logic [31:0]      fwd_rs_o,
    output logic [31:0]      fwd_rt_o
);

    logic [4:0]       rd_mem_q   [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [4:0]       wb_rd_q,  wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_regwrite_q, wb_regwrite_d;

    logic push_fire;
    logic store;
    logic pop;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        push_ready_o  = (count_q != (PTR_W+1)'(DEPTH));
        push_fire     = push_valid_i & push_ready_o;
        // Writes to r0 complete the handshake but are discarded.
        store         = push_fire && (push_rd_i != 5'd0);
        pop           = (count_q != '0) && !wb_stall_i;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        wb_regwrite_d = 1'b0;

        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            wb_rd_d       = rd_mem_q[rd_ptr_q];
            wb_data_d     = data_mem_q[rd_ptr_q];
            wb_regwrite_d = 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
    end

    // NOTE: entry storage carries no reset; validity is defined solely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (store) begin
            rd_mem_q[wr_ptr_q]   <= push_rd_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_regwrite_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_regwrite_q <= wb_regwrite_d;
        end
    end

    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign wb_regwrite_o = wb_regwrite_q;
    assign q_count_o     = count_q;

`ifdef WBQ_BYPASS_EN
    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    // Older sources are applied first so younger matches overwrite them:
    // the write-port entry is older than anything still queued, and queue
    // slots are walked head (oldest) to tail (youngest).
    function automatic fwd_t lookup(input logic [4:0] q);
        fwd_t             r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (q != 5'd0) begin
            if (wb_regwrite_q && (wb_rd_q == q)) begin
                r.hit  = 1'b1;
                r.data = wb_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr_q + PTR_W'(k);
                if (((PTR_W+1)'(k) < count_q) && (rd_mem_q[idx] == q)) begin
                    r.hit  = 1'b1;
                    r.data = data_mem_q[idx];
                end
            end
        end
        return r;
    endfunction

    fwd_t rs_res, rt_res;

    always_comb begin
        rs_res = lookup(q_rs_i);
        rt_res = lookup(q_rt_i);
    end

    assign fwd_rs_hit_o = rs_res.hit;
    assign fwd_rs_o     = rs_res.data;
    assign fwd_rt_hit_o = rt_res.hit;
    assign fwd_rt_o     = rt_res.data;
`else
    logic unused_lookup;
    assign unused_lookup = ^{q_rs_i, q_rt_i};

    assign fwd_rs_hit_o = 1'b0;
    assign fwd_rs_o     = '0;
    assign fwd_rt_hit_o = 1'b0;
    assign fwd_rt_o     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//   Self-checking bench for regfile_wb_queue. Accepted non-r0 pushes are
//   queued as expectations; each retire cycle pops and compares one.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic             clk_i;
    logic             rst_i;
    logic             push_valid_i;
    logic             push_ready_o;
    logic [4:0]       push_rd_i;
    logic [31:0]      push_data_i;
    logic             wb_stall_i;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;
    logic             wb_regwrite_o;
    logic [PTR_W:0]   q_count_o;
    logic [4:0]       q_rs_i;
    logic [4:0]       q_rt_i;
    logic             fwd_rs_hit_o;
    logic             fwd_rt_hit_o;
    logic [31:0]      fwd_rs_o;
    logic [31:0]      fwd_rt_o;

    int  n_checks = 0;
    int  n_errors = 0;
    wb_t exp_q[$];

    regfile_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_rd_i    (push_rd_i),
        .push_data_i  (push_data_i),
        .wb_stall_i   (wb_stall_i),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_regwrite_o(wb_regwrite_o),
        .q_count_o    (q_count_o),
        .q_rs_i       (q_rs_i),
        .q_rt_i       (q_rt_i),
        .fwd_rs_hit_o (fwd_rs_hit_o),
        .fwd_rt_hit_o (fwd_rt_hit_o),
        .fwd_rs_o     (fwd_rs_o),
        .fwd_rt_o     (fwd_rt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Retire monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && wb_regwrite_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_retire", 32'd0, 32'd1);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("retire_rd",   32'(wb_rd_o), 32'(e.rd));
                check("retire_data", wb_data_o,    e.data);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with push_valid_i low.
    task automatic do_push(input logic [4:0] rd, input logic [31:0] data, output bit accepted);
        bit rdy;
        accepted     = 1'b0;
        push_valid_i = 1'b1;
        push_rd_i    = rd;
        push_data_i  = data;
        for (int n = 0; n < 50; n++) begin
            rdy = push_ready_o;
            @(posedge clk_i);
            if (rdy) begin
                accepted = 1'b1;
                if (rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
                break;
            end
            @(negedge clk_i);
        end
        if (!accepted) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        push_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0 && q_count_o == '0 && wb_regwrite_o == 1'b0) break;
            @(negedge clk_i);
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_count", 32'(q_count_o), 32'd0);
    endtask

    task automatic check_fwd(input string tag, input logic rs_hit, input logic [31:0] rs,
                             input logic rt_hit, input logic [31:0] rt);
`ifdef WBQ_BYPASS_EN
        check({tag, "_rs_hit"}, 32'(fwd_rs_hit_o), 32'(rs_hit));
        check({tag, "_rs"},     fwd_rs_o,          rs);
        check({tag, "_rt_hit"}, 32'(fwd_rt_hit_o), 32'(rt_hit));
        check({tag, "_rt"},     fwd_rt_o,          rt);
`else
        // Without the bypass build every forwarding output stays zero.
        check({tag, "_rs_hit"}, 32'(fwd_rs_hit_o), 32'(rs_hit & 1'b0));
        check({tag, "_rs"},     fwd_rs_o,          rs & 32'd0);
        check({tag, "_rt_hit"}, 32'(fwd_rt_hit_o), 32'(rt_hit & 1'b0));
        check({tag, "_rt"},     fwd_rt_o,          rt & 32'd0);
`endif
    endtask

    initial begin
        bit acc;

        rst_i        = 1'b1;
        push_valid_i = 1'b0;
        push_rd_i    = '0;
        push_data_i  = '0;
        wb_stall_i   = 1'b0;
        q_rs_i       = '0;
        q_rt_i       = '0;

        // Reset state
        #1;
        check("rst_regwrite", 32'(wb_regwrite_o), 32'd0);
        check("rst_count",    32'(q_count_o),     32'd0);
        check("rst_wb_rd",    32'(wb_rd_o),       32'd0);
        check("rst_wb_data",  wb_data_o,          32'd0);
        check("rst_ready",    32'(push_ready_o),  32'd1);
        check_fwd("rst_fwd", 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 1: single push, two-edge latency
        do_push(5'd5, 32'hDEAD_BEEF, acc);
        check("t1_count_after_push", 32'(q_count_o),     32'd1);
        check("t1_no_early_wb",      32'(wb_regwrite_o), 32'd0);
        @(negedge clk_i);
        check("t1_wb_high", 32'(wb_regwrite_o), 32'd1);
        check("t1_wb_rd",   32'(wb_rd_o),       32'd5);
        check("t1_wb_data", wb_data_o,          32'hDEAD_BEEF);
        @(negedge clk_i);
        check("t1_wb_one_cycle", 32'(wb_regwrite_o), 32'd0);
        check("t1_wb_rd_hold",   32'(wb_rd_o),       32'd5);
        check("t1_count_empty",  32'(q_count_o),     32'd0);

        // 2: fill under stall, held fifth push, release
        wb_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) do_push(5'(i), 32'h100 + 32'(i), acc);
        check("t2_count_full", 32'(q_count_o),    32'd4);
        check("t2_not_ready",  32'(push_ready_o), 32'd0);
        fork
            do_push(5'd5, 32'h105, acc);
            begin
                repeat (2) @(negedge clk_i);
                check("t2_still_full",   32'(q_count_o),     32'd4);
                check("t2_stall_no_wb",  32'(wb_regwrite_o), 32'd0);
                wb_stall_i = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    check("t2_back_to_back", 32'(wb_regwrite_o), 32'd1);
                end
            end
        join
        wait_drain();

        // 3: push to r0 is accepted and dropped
        do_push(5'd0, 32'h1234, acc);
        check("t3_accepted", 32'(acc),       32'd1);
        check("t3_count",    32'(q_count_o), 32'd0);
        repeat (4) @(negedge clk_i);
        check("t3_no_wb", 32'(wb_regwrite_o), 32'd0);

        // 4: steady push+pop across pointer wrap
        wb_stall_i = 1'b1;
        do_push(5'd20, 32'hA000_0000, acc);
        do_push(5'd21, 32'hA000_0001, acc);
        wb_stall_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_push(5'(1 + (i % 31)), $urandom, acc);
            check("t4_count_steady", 32'(q_count_o), 32'd2);
        end
        wait_drain();

        // 5: forwarding, queue path youngest first, then write-port path
        wb_stall_i = 1'b1;
        do_push(5'd7, 32'd1, acc);
        do_push(5'd7, 32'd2, acc);
        q_rs_i = 5'd7;
        q_rt_i = 5'd0;
        #1;
        check_fwd("t5_queued", 1'b1, 32'd2, 1'b0, 32'd0);
        wb_stall_i = 1'b0;
        @(negedge clk_i);
        check_fwd("t5_one_left", 1'b1, 32'd2, 1'b0, 32'd0);
        @(negedge clk_i);
        check("t5_wb_data", wb_data_o, 32'd2);
        check("t5_empty",   32'(q_count_o), 32'd0);
        check_fwd("t5_wb_path", 1'b1, 32'd2, 1'b0, 32'd0);
        @(negedge clk_i);
        check_fwd("t5_miss", 1'b0, 32'd0, 1'b0, 32'd0);
        q_rs_i = 5'd0;

        // 6: reset mid-operation discards everything
        wb_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) do_push(5'(9 + i), 32'h600 + 32'(i), acc);
        wb_stall_i = 1'b0;
        @(negedge clk_i);
        check("t6_inflight", 32'(wb_regwrite_o), 32'd1);
        check("t6_queued",   32'(q_count_o),     32'd3);
        #1;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        check("t6_rst_regwrite", 32'(wb_regwrite_o), 32'd0);
        check("t6_rst_count",    32'(q_count_o),     32'd0);
        check("t6_rst_ready",    32'(push_ready_o),  32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("t6_nothing_after", 32'(q_count_o), 32'd0);
        check("t6_sb_empty",      32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
